// File: rtl/avalon_mm_pkg.sv
// Shared encodings for the two-master Avalon-MM arbiter: FSM states and response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avalon_mm_pkg;

    // Arbiter FSM: idle, or owning the slave on behalf of master 0 / master 1
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    // Avalon-MM response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/avalon_mm_rr_arb.sv
// Two-input round-robin grant decision: on a tie the port that did not win last gets the grant.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only samples the grant while it is idle.
module avalon_mm_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_vld,
    output logic       grant
);

    // Single requester wins outright; a tie goes to the port opposite the last winner
    always_comb begin
        grant_vld = |req;
        grant     = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/avalon_mm_arbiter_2.sv
// Two-master to one-slave Avalon-MM arbiter, round-robin, one transfer per grant.
// Latency: slave sees the command one cycle after the request is seen idle; one idle bubble between grants.
// Backpressure: granted master follows slave waitrequest, other master held with waitrequest=1.
// Optional watchdog AVALON_MM_ARB_TIMEOUT_EN forces SLVERR after TIMEOUT_CYCLES stalled cycles.
module avalon_mm_arbiter_2
    import avalon_mm_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [ADDR_WIDTH-1:0]       avalon_mm_in0_address,
    input  logic [BYTEENABLE_WIDTH-1:0] avalon_mm_in0_byteenable,
    input  logic                        avalon_mm_in0_read,
    input  logic                        avalon_mm_in0_write,
    input  logic [DATA_WIDTH-1:0]       avalon_mm_in0_writedata,
    output logic [DATA_WIDTH-1:0]       avalon_mm_in0_readdata,
    output logic [1:0]                  avalon_mm_in0_response,
    output logic                        avalon_mm_in0_waitrequest,

    input  logic [ADDR_WIDTH-1:0]       avalon_mm_in1_address,
    input  logic [BYTEENABLE_WIDTH-1:0] avalon_mm_in1_byteenable,
    input  logic                        avalon_mm_in1_read,
    input  logic                        avalon_mm_in1_write,
    input  logic [DATA_WIDTH-1:0]       avalon_mm_in1_writedata,
    output logic [DATA_WIDTH-1:0]       avalon_mm_in1_readdata,
    output logic [1:0]                  avalon_mm_in1_response,
    output logic                        avalon_mm_in1_waitrequest,

    output logic [ADDR_WIDTH-1:0]       avalon_mm_out_address,
    output logic [BYTEENABLE_WIDTH-1:0] avalon_mm_out_byteenable,
    output logic                        avalon_mm_out_read,
    output logic                        avalon_mm_out_write,
    output logic [DATA_WIDTH-1:0]       avalon_mm_out_writedata,
    input  logic [DATA_WIDTH-1:0]       avalon_mm_out_readdata,
    input  logic [1:0]                  avalon_mm_out_response,
    input  logic                        avalon_mm_out_waitrequest,

    output logic                        timeout_event
);

    // A watchdog below two cycles could not distinguish first stall from expiry
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t state;
    logic       last_grant;
    logic [1:0] req;
    logic       grant_vld;
    logic       grant;
    logic       busy0;
    logic       busy1;
    logic       req_g;
    logic       timeout_hit;

    assign req = {avalon_mm_in1_read | avalon_mm_in1_write,
                  avalon_mm_in0_read | avalon_mm_in0_write};

    // Reset gates the busy decode so every output shows idle values while rst is high,
    // including the cycle in which rst first arrives mid-transfer.
    assign busy0 = (state == BUSY0) && !rst;
    assign busy1 = (state == BUSY1) && !rst;
    assign req_g = busy1 ? req[1] : req[0];

    avalon_mm_rr_arb u_rr_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

`ifdef AVALON_MM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             leave_busy;

    // Expiry only matters while the master is still asking; a dropped request ends the grant anyway
    assign timeout_hit = (busy0 || busy1) && req_g && (stall_cnt == CNT_LAST);
    assign leave_busy  = !req_g || !avalon_mm_out_waitrequest || timeout_hit;

    // Count stalled busy cycles; cleared whenever the FSM changes state
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!(busy0 || busy1) || leave_busy) begin
            stall_cnt <= '0;
        end else if (avalon_mm_out_waitrequest) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout_event = timeout_hit;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_event = 1'b0;
`endif

    // Grant FSM: idle -> busy on a grant, back to idle on completion, timeout or dropped request
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state <= grant ? BUSY1 : BUSY0;
                    end
                end
                BUSY0: begin
                    if (!req[0]) begin
                        state <= IDLE;
                    end else if (!avalon_mm_out_waitrequest || timeout_hit) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                BUSY1: begin
                    if (!req[1]) begin
                        state <= IDLE;
                    end else if (!avalon_mm_out_waitrequest || timeout_hit) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command/response routing; the non-granted master sees a stalled, empty, OKAY port
    always_comb begin
        avalon_mm_out_address      = '0;
        avalon_mm_out_byteenable   = '0;
        avalon_mm_out_read         = 1'b0;
        avalon_mm_out_write        = 1'b0;
        avalon_mm_out_writedata    = '0;
        avalon_mm_in0_waitrequest  = 1'b1;
        avalon_mm_in0_readdata     = '0;
        avalon_mm_in0_response     = RESP_OKAY;
        avalon_mm_in1_waitrequest  = 1'b1;
        avalon_mm_in1_readdata     = '0;
        avalon_mm_in1_response     = RESP_OKAY;
        if (busy0) begin
            avalon_mm_out_address     = avalon_mm_in0_address;
            avalon_mm_out_byteenable  = avalon_mm_in0_byteenable;
            avalon_mm_out_read        = avalon_mm_in0_read;
            avalon_mm_out_write       = avalon_mm_in0_write;
            avalon_mm_out_writedata   = avalon_mm_in0_writedata;
            avalon_mm_in0_waitrequest = avalon_mm_out_waitrequest;
            avalon_mm_in0_readdata    = avalon_mm_out_readdata;
            avalon_mm_in0_response    = avalon_mm_out_response;
            if (timeout_hit) begin
                avalon_mm_out_read        = 1'b0;
                avalon_mm_out_write       = 1'b0;
                avalon_mm_in0_waitrequest = 1'b0;
                avalon_mm_in0_readdata    = '0;
                avalon_mm_in0_response    = RESP_SLVERR;
            end
        end else if (busy1) begin
            avalon_mm_out_address     = avalon_mm_in1_address;
            avalon_mm_out_byteenable  = avalon_mm_in1_byteenable;
            avalon_mm_out_read        = avalon_mm_in1_read;
            avalon_mm_out_write       = avalon_mm_in1_write;
            avalon_mm_out_writedata   = avalon_mm_in1_writedata;
            avalon_mm_in1_waitrequest = avalon_mm_out_waitrequest;
            avalon_mm_in1_readdata    = avalon_mm_out_readdata;
            avalon_mm_in1_response    = avalon_mm_out_response;
            if (timeout_hit) begin
                avalon_mm_out_read        = 1'b0;
                avalon_mm_out_write       = 1'b0;
                avalon_mm_in1_waitrequest = 1'b0;
                avalon_mm_in1_readdata    = '0;
                avalon_mm_in1_response    = RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter_2.sv
// Directed bench for the two-master Avalon-MM arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Watchdog scenario selected by AVALON_MM_ARB_TIMEOUT_EN, otherwise an indefinite stall is checked.
module tb_avalon_mm_arbiter_2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in0_address, in1_address;
    logic [3:0]  in0_byteenable, in1_byteenable;
    logic        in0_read, in0_write, in1_read, in1_write;
    logic [31:0] in0_writedata, in1_writedata;
    logic [31:0] in0_readdata, in1_readdata;
    logic [1:0]  in0_response, in1_response;
    logic        in0_waitrequest, in1_waitrequest;
    logic [31:0] out_address;
    logic [3:0]  out_byteenable;
    logic        out_read, out_write;
    logic [31:0] out_writedata;
    logic [31:0] out_readdata;
    logic [1:0]  out_response;
    logic        out_waitrequest;
    logic        timeout_event;

    int n_cmp = 0;
    int n_err = 0;
    int grants0, grants1;

    always #5 clk = ~clk;

    avalon_mm_arbiter_2 #(
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .BYTEENABLE_WIDTH (4),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .avalon_mm_in0_address     (in0_address),
        .avalon_mm_in0_byteenable  (in0_byteenable),
        .avalon_mm_in0_read        (in0_read),
        .avalon_mm_in0_write       (in0_write),
        .avalon_mm_in0_writedata   (in0_writedata),
        .avalon_mm_in0_readdata    (in0_readdata),
        .avalon_mm_in0_response    (in0_response),
        .avalon_mm_in0_waitrequest (in0_waitrequest),
        .avalon_mm_in1_address     (in1_address),
        .avalon_mm_in1_byteenable  (in1_byteenable),
        .avalon_mm_in1_read        (in1_read),
        .avalon_mm_in1_write       (in1_write),
        .avalon_mm_in1_writedata   (in1_writedata),
        .avalon_mm_in1_readdata    (in1_readdata),
        .avalon_mm_in1_response    (in1_response),
        .avalon_mm_in1_waitrequest (in1_waitrequest),
        .avalon_mm_out_address     (out_address),
        .avalon_mm_out_byteenable  (out_byteenable),
        .avalon_mm_out_read        (out_read),
        .avalon_mm_out_write       (out_write),
        .avalon_mm_out_writedata   (out_writedata),
        .avalon_mm_out_readdata    (out_readdata),
        .avalon_mm_out_response    (out_response),
        .avalon_mm_out_waitrequest (out_waitrequest),
        .timeout_event             (timeout_event)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_masters();
        in0_address = '0; in0_byteenable = '0; in0_read = 0; in0_write = 0; in0_writedata = '0;
        in1_address = '0; in1_byteenable = '0; in1_read = 0; in1_write = 0; in1_writedata = '0;
        out_readdata = '0; out_response = 2'b00; out_waitrequest = 1'b1;
    endtask

    // Reset with both masters requesting: outputs must still show idle values
    task automatic reset_dut();
        rst = 1'b1;
        clear_masters();
        in0_read = 1'b1; in1_write = 1'b1;
        tick(); tick();
        settle();
        chk("rst_out_read", {31'b0, out_read}, 32'd0);
        chk("rst_out_write", {31'b0, out_write}, 32'd0);
        chk("rst_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
        chk("rst_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        chk("rst_timeout_event", {31'b0, timeout_event}, 32'd0);
        tick();
        rst = 1'b0;
        clear_masters();
    endtask

    initial begin
        rst = 1'b1;
        clear_masters();

        // ---- Single read from port 0, two slave stall cycles ----
        reset_dut();
        in0_read = 1; in0_address = 32'h10; in0_byteenable = 4'hF;
        settle();
        chk("rd_idle_out_read", {31'b0, out_read}, 32'd0);
        chk("rd_idle_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
        tick(); settle();
        chk("rd_b1_out_read", {31'b0, out_read}, 32'd1);
        chk("rd_b1_out_addr", out_address, 32'h10);
        chk("rd_b1_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
        chk("rd_b1_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        tick(); settle();
        chk("rd_b2_out_read", {31'b0, out_read}, 32'd1);
        chk("rd_b2_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
        tick();
        out_waitrequest = 0; out_readdata = 32'hDEADBEEF; out_response = 2'b00;
        settle();
        chk("rd_done_in0_wait", {31'b0, in0_waitrequest}, 32'd0);
        chk("rd_done_in0_data", in0_readdata, 32'hDEADBEEF);
        chk("rd_done_in0_resp", {30'b0, in0_response}, 32'd0);
        chk("rd_done_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        chk("rd_done_in1_data", in1_readdata, 32'd0);
        tick();
        in0_read = 0; out_waitrequest = 1;
        settle();
        chk("rd_after_out_read", {31'b0, out_read}, 32'd0);
        chk("rd_after_in0_wait", {31'b0, in0_waitrequest}, 32'd1);

        // ---- Simultaneous writes after reset: port 0 first, bubble, then port 1 ----
        reset_dut();
        out_waitrequest = 0;
        in0_write = 1; in0_address = 32'hA0; in0_writedata = 32'h11; in0_byteenable = 4'hF;
        in1_write = 1; in1_address = 32'hB0; in1_writedata = 32'h22; in1_byteenable = 4'h3;
        settle();
        chk("wr_idle_out_write", {31'b0, out_write}, 32'd0);
        tick(); settle();
        chk("wr_p0_out_write", {31'b0, out_write}, 32'd1);
        chk("wr_p0_out_addr", out_address, 32'hA0);
        chk("wr_p0_out_data", out_writedata, 32'h11);
        chk("wr_p0_in0_wait", {31'b0, in0_waitrequest}, 32'd0);
        chk("wr_p0_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        tick();
        in0_write = 0;
        settle();
        chk("wr_bubble_out_write", {31'b0, out_write}, 32'd0);
        chk("wr_bubble_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        tick(); settle();
        chk("wr_p1_out_write", {31'b0, out_write}, 32'd1);
        chk("wr_p1_out_addr", out_address, 32'hB0);
        chk("wr_p1_out_data", out_writedata, 32'h22);
        chk("wr_p1_out_be", {28'b0, out_byteenable}, 32'h3);
        chk("wr_p1_in1_wait", {31'b0, in1_waitrequest}, 32'd0);
        chk("wr_p1_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
        tick();
        in1_write = 0;

        // ---- Continuous requests from both: strict alternation, last winner was port 1 ----
        in0_read = 1; in0_address = 32'h100;
        in1_read = 1; in1_address = 32'h200;
        grants0 = 0; grants1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); settle();
            chk("rr_out_read", {31'b0, out_read}, 32'd1);
            chk("rr_out_addr", out_address, (i % 2 == 0) ? 32'h100 : 32'h200);
            if (out_address == 32'h100) grants0++;
            if (out_address == 32'h200) grants1++;
            tick(); settle();
            chk("rr_bubble_out_read", {31'b0, out_read}, 32'd0);
        end
        chk("rr_grants0", grants0, 32'd4);
        chk("rr_grants1", grants1, 32'd4);
        in0_read = 0; in1_read = 0;

        // ---- Reset during a stalled port 1 write ----
        reset_dut();
        in1_write = 1; in1_address = 32'hC0; in1_writedata = 32'h33;
        tick(); settle();
        chk("rstmid_b1_out_write", {31'b0, out_write}, 32'd1);
        chk("rstmid_b1_out_addr", out_address, 32'hC0);
        tick();
        rst = 1;
        settle();
        chk("rstmid_during_out_write", {31'b0, out_write}, 32'd0);
        chk("rstmid_during_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        tick();
        rst = 0;
        in0_write = 1; in0_address = 32'hD0;
        settle();
        chk("rstmid_idle_out_write", {31'b0, out_write}, 32'd0);
        tick(); settle();
        chk("rstmid_tie_out_addr", out_address, 32'hD0);
        chk("rstmid_tie_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
        tick();
        in0_write = 0; in1_write = 0;

`ifdef AVALON_MM_ARB_TIMEOUT_EN
        // ---- Slave stuck: port 0 released with SLVERR in its 8th busy cycle ----
        reset_dut();
        out_waitrequest = 1; out_readdata = 32'h12345678; out_response = 2'b00;
        in0_read = 1; in0_address = 32'h40;
        for (int c = 1; c <= 7; c++) begin
            tick(); settle();
            chk("to_stall_event", {31'b0, timeout_event}, 32'd0);
            chk("to_stall_in0_wait", {31'b0, in0_waitrequest}, 32'd1);
            chk("to_stall_out_read", {31'b0, out_read}, 32'd1);
        end
        tick(); settle();
        chk("to_hit_event", {31'b0, timeout_event}, 32'd1);
        chk("to_hit_in0_wait", {31'b0, in0_waitrequest}, 32'd0);
        chk("to_hit_in0_resp", {30'b0, in0_response}, 32'h2);
        chk("to_hit_in0_data", in0_readdata, 32'd0);
        chk("to_hit_out_read", {31'b0, out_read}, 32'd0);
        tick();
        in0_read = 0;
        settle();
        chk("to_after_event", {31'b0, timeout_event}, 32'd0);
        in0_read = 1; in1_read = 1; in1_address = 32'h44;
        tick(); settle();
        chk("to_next_tie_addr", out_address, 32'h44);
        in0_read = 0; in1_read = 0;
`else
        // ---- Slave stuck, no watchdog: grant held past 8 cycles, then master withdraws ----
        reset_dut();
        out_waitrequest = 1;
        in1_read = 1; in1_address = 32'h50;
        for (int c = 1; c <= 12; c++) begin
            tick(); settle();
            chk("stall_in1_wait", {31'b0, in1_waitrequest}, 32'd1);
            chk("stall_out_read", {31'b0, out_read}, 32'd1);
            chk("stall_event", {31'b0, timeout_event}, 32'd0);
        end
        // Withdrawal is not a completion: last winner remains port 1 from reset, so port 0 wins tie
        tick();
        in1_read = 0;
        settle();
        chk("drop_out_read", {31'b0, out_read}, 32'd0);
        tick();
        out_waitrequest = 0;
        in0_read = 1; in0_address = 32'h60;
        in1_read = 1; in1_address = 32'h70;
        settle();
        chk("drop_idle_out_read", {31'b0, out_read}, 32'd0);
        tick(); settle();
        chk("drop_tie_out_addr", out_address, 32'h60);
        in0_read = 0; in1_read = 0;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/avalon_mm_arbiter_2.md
AVALON_MM_ARBITER_2 -- requirements
Module: avalon_mm_arbiter_2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter BYTEENABLE_WIDTH, default DATA_WIDTH/8, byteenable width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, waitrequest cycles before forced termination; must be ≥2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-007 SHALL have port avalon_mm_inN_address (N=0,1), input, ADDR_WIDTH, master N address.
REQ-008 SHALL have port avalon_mm_inN_byteenable, input, BYTEENABLE_WIDTH, master N byte enables.
REQ-009 SHALL have port avalon_mm_inN_read, input, 1, master N read request.
REQ-010 SHALL have port avalon_mm_inN_write, input, 1, master N write request.
REQ-011 SHALL have port avalon_mm_inN_writedata, input, DATA_WIDTH, master N write data.
REQ-012 SHALL have port avalon_mm_inN_readdata, output, DATA_WIDTH, read data to master N.
REQ-013 SHALL have port avalon_mm_inN_response, output, 2, response to master N (00 OKAY, 10 SLVERR).
REQ-014 SHALL have port avalon_mm_inN_waitrequest, output, 1, stall to master N.
REQ-015 SHALL have ports avalon_mm_out_{address,byteenable,read,write,writedata} as outputs and avalon_mm_out_{readdata,response,waitrequest} as inputs, same widths as inN, single slave side.
REQ-016 SHALL have port timeout_event, output, 1, one-cycle pulse on forced termination.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY0, BUSY1; request N = inN_read | inN_write.
REQ-018 In IDLE SHALL drive out_read=out_write=0, both inN_waitrequest=1.
REQ-019 In IDLE with one request SHALL go to BUSY of that port next edge; with both, to the port != last_grant (round-robin); none: stay IDLE.
REQ-020 In BUSYn SHALL route inN address/byteenable/read/write/writedata to out combinationally; inN_waitrequest = out_waitrequest; inN_readdata/response = out_readdata/response.
REQ-021 Non-granted port SHALL see waitrequest=1, readdata=0, response=00.
REQ-022 Transfer completes in a BUSYn cycle with out_waitrequest=0; SHALL return to IDLE next edge and set last_grant=n.
REQ-023 Latency: issue one cycle after request first seen in IDLE; one IDLE bubble between consecutive grants.
REQ-024 If granted master drops read and write while BUSYn (protocol violation), SHALL return to IDLE next edge without updating last_grant.
REQ-025 Simultaneous read and write SHALL be forwarded unchanged, not checked.

Reset
REQ-026 On rst SHALL enter IDLE, last_grant=1 (port 0 wins first tie), timeout counter=0, timeout_event=0; rst mid-transfer aborts it with out_read/out_write=0 next cycle.
REQ-027 All outputs SHALL take IDLE values during reset.

Configuration
REQ-028 With AVALON_MM_ARB_TIMEOUT_EN defined: counter counts BUSY cycles with out_waitrequest=1, clears on state change; in cycle counter==TIMEOUT_CYCLES-1 SHALL drive inN_waitrequest=0, response=10, readdata=0, out_read=out_write=0, timeout_event=1, then IDLE with last_grant=n.
REQ-029 Without AVALON_MM_ARB_TIMEOUT_EN: no counter, timeout_event tied 0, slave may stall indefinitely.

Structure
REQ-030 Response codes (OKAY=2'b00, SLVERR=2'b10) and state encodings SHALL live in shared package avalon_mm_pkg.
REQ-031 Grant decision SHALL be sub-module avalon_mm_rr_arb (2-input round-robin, request/last_grant in, grant out); mux and FSM in top.

Verification
REQ-032 Port 0 read addr 0x10, slave waitrequest 2 cycles, readdata 0xDEADBEEF -> out_read asserted 1 cycle after request, in0 gets 0xDEADBEEF, response 00, in1 waitrequest=1 throughout.
REQ-033 Both ports write same cycle after reset (0xA0/0x11, 0xB0/0x22) -> port 0 served first, then port 1 after one IDLE bubble; slave sees 0x11 then 0x22.
REQ-034 Both ports continuously request 4 transfers each -> grants alternate 0,1,0,1..., no starvation.
REQ-035 rst pulsed during BUSY1 with waitrequest=1 -> next cycle IDLE, out_write=0, next tie goes to port 0.
REQ-036 With AVALON_MM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave waitrequest stuck 1 -> port 0 released in 8th BUSY cycle with response 10, readdata 0, timeout_event one-cycle pulse.
